clint_timer: RTL

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer_pkg.sv | 37 +++
 rtl/clint_prescaler.sv | 29 ++
 rtl/clint_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_pkg.sv
// Shared constants for the CLINT timer: register map, interrupt code, FSM encoding.
// Optional prescaler is enabled with `define CLINT_PRESCALER_EN.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 4
`endif

package clint_timer_pkg;

  localparam int XLEN    = `MAX_BIT_POS + 1;
  localparam int MTIME_W = 2 * XLEN;
  localparam int PRE_W   = 16;

  localparam logic [4:0] ADDR_MSIP        = 5'h00;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] ADDR_MTIME_LO    = 5'h0C;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h10;
  localparam logic [4:0] ADDR_PRESCALE    = 5'h14;

  localparam logic [`INT_CODE_WIDTH-1:0] SOFT_INT_CODE = `INT_CODE_WIDTH'(3);

  localparam logic [MTIME_W-1:0] MTIMECMP_RST = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  // Word-aligned and inside the six-register window.
  function automatic logic addr_mapped(input logic [4:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= ADDR_PRESCALE);
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator for mtime: fires when the counter reaches the programmed prescale.
// Only built when CLINT_PRESCALER_EN is defined.
`ifdef CLINT_PRESCALER_EN
module clint_prescaler
  import clint_timer_pkg::*;
(
  input  logic             clk_timer,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clear,
  output logic             tick
);

  logic [PRE_W-1:0] count;

  assign tick = (count == prescale);

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + PRE_W'(1);
    end
  end

endmodule
`endif

// File: rtl/clint_timer.sv
// CLINT timer block: msip, 64-bit mtime/mtimecmp, bus slave with one-cycle ack.
// Define CLINT_PRESCALER_EN to make the mtime tick rate programmable at 0x14.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 4
`endif

// state   | meaning
// ST_IDLE | waiting for bus_req; a request here is captured and executed
// ST_ACK  | bus_ack/bus_err/bus_rdata valid for this single cycle
module clint_timer
  import clint_timer_pkg::*;
(
  input  logic                       clk_timer,
  input  logic                       rst,
  input  logic                       bus_req,
  input  logic                       bus_we,
  input  logic [4:0]                 bus_addr,
  input  logic [XLEN-1:0]            bus_wdata,
  output logic [XLEN-1:0]            bus_rdata,
  output logic                       bus_ack,
  output logic                       bus_err,
  output logic [XLEN-1:0]            mtimecmp_low,
  output logic [XLEN-1:0]            mtimecmp_high,
  output logic                       set_mtimecmp_low,
  output logic                       set_mtimecmp_high,
  output logic                       timer_irq,
  output logic [`INT_CODE_WIDTH-1:0] soft_int_code
);

  bus_state_e state, state_nxt;
  logic       capture;

  logic       addr_ok;
  logic       wr_en;
  logic       rd_en;
  logic       wr_msip;
  logic       wr_cmp_lo;
  logic       wr_cmp_hi;
  logic       wr_mtime_lo;
  logic       wr_mtime_hi;
  logic       rd_mtime_lo;

  logic [XLEN-1:0]    rdata_nxt;
  logic [XLEN-1:0]    prescale_rd;
  logic               tick;
  logic               msip;
  logic [MTIME_W-1:0] mtime;
  logic [MTIME_W-1:0] mtimecmp;
  logic [XLEN-1:0]    hi_shadow;

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus_req) begin
          state_nxt = ST_ACK;
          capture   = 1'b1;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addr_ok     = addr_mapped(bus_addr);
  assign wr_en       = capture && bus_we && addr_ok;
  assign rd_en       = capture && !bus_we && addr_ok;
  assign wr_msip     = wr_en && (bus_addr == ADDR_MSIP);
  assign wr_cmp_lo   = wr_en && (bus_addr == ADDR_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (bus_addr == ADDR_MTIMECMP_HI);
  assign wr_mtime_lo = wr_en && (bus_addr == ADDR_MTIME_LO);
  assign wr_mtime_hi = wr_en && (bus_addr == ADDR_MTIME_HI);
  assign rd_mtime_lo = rd_en && (bus_addr == ADDR_MTIME_LO);

  always_comb begin
    rdata_nxt = '0;
    if (rd_en) begin
      case (bus_addr)
        ADDR_MSIP:        rdata_nxt = {{(XLEN-1){1'b0}}, msip};
        ADDR_MTIMECMP_LO: rdata_nxt = mtimecmp[XLEN-1:0];
        ADDR_MTIMECMP_HI: rdata_nxt = mtimecmp[MTIME_W-1:XLEN];
        ADDR_MTIME_LO:    rdata_nxt = mtime[XLEN-1:0];
        ADDR_MTIME_HI:    rdata_nxt = hi_shadow;
        ADDR_PRESCALE:    rdata_nxt = prescale_rd;
        default:          rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      bus_ack           <= 1'b0;
      bus_err           <= 1'b0;
      bus_rdata         <= '0;
      set_mtimecmp_low  <= 1'b0;
      set_mtimecmp_high <= 1'b0;
    end else begin
      bus_ack           <= capture;
      bus_err           <= capture && !addr_ok;
      bus_rdata         <= rdata_nxt;
      set_mtimecmp_low  <= wr_cmp_lo;
      set_mtimecmp_high <= wr_cmp_hi;
    end
  end

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      msip     <= 1'b0;
      mtimecmp <= MTIMECMP_RST;
    end else begin
      if (wr_msip)   msip                     <= bus_wdata[0];
      if (wr_cmp_lo) mtimecmp[XLEN-1:0]       <= bus_wdata;
      if (wr_cmp_hi) mtimecmp[MTIME_W-1:XLEN] <= bus_wdata;
    end
  end

  // A bus write to either half replaces that cycle's increment entirely.
  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[XLEN-1:0] <= bus_wdata;
    end else if (wr_mtime_hi) begin
      mtime[MTIME_W-1:XLEN] <= bus_wdata;
    end else if (tick) begin
      mtime <= mtime + MTIME_W'(1);
    end
  end

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      hi_shadow <= '0;
    end else if (rd_mtime_lo) begin
      hi_shadow <= mtime[MTIME_W-1:XLEN];
    end
  end

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  assign mtimecmp_low  = mtimecmp[XLEN-1:0];
  assign mtimecmp_high = mtimecmp[MTIME_W-1:XLEN];
  assign soft_int_code = msip ? SOFT_INT_CODE : '0;

`ifdef CLINT_PRESCALER_EN
  logic [PRE_W-1:0] prescale;
  logic             wr_prescale;

  assign wr_prescale = wr_en && (bus_addr == ADDR_PRESCALE);

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
    end else if (wr_prescale) begin
      prescale <= bus_wdata[PRE_W-1:0];
    end
  end

  clint_prescaler u_prescaler (
    .clk_timer (clk_timer),
    .rst       (rst),
    .prescale  (prescale),
    .clear     (wr_prescale),
    .tick      (tick)
  );

  assign prescale_rd = {{(XLEN-PRE_W){1'b0}}, prescale};
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

endmodule
